// File: rtl/led_pwm_driver.sv
// LED pin output stage: global PWM dimming plus optional per-LED blinking.
// Blink logic is present only when LED_BLINK_EN is defined.
module led_pwm_driver #(
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned BLINK_W  = 24
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [16:0] i_ledr,
   input  logic [7:0]  i_ledg,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [31:0] cfg_data,
   output logic [16:0] o_ledr_pin,
   output logic [7:0]  o_ledg_pin,
   output logic        o_pwm_tick
);

   localparam int unsigned NLED = 25;
   localparam logic [PWM_BITS-1:0] DMAX     = '1;
   localparam logic [PWM_BITS-1:0] CNT_LAST = DMAX - PWM_BITS'(1);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] duty_sh_q, duty_sh_d;
   logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
   logic [NLED-1:0]     pin_q, pin_d;
   logic [NLED-1:0]     gate_c;
   logic                wrap_c;
   logic                on_c;
   logic                unused_cfg_bits;

   assign unused_cfg_bits = ^cfg_data;
   assign wrap_c = (pwm_cnt_q == CNT_LAST);
   assign on_c   = (duty_act_q == DMAX) | (pwm_cnt_q < duty_act_q);

   // PWM counter and duty shadow/active pair
   always_comb begin
      pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
      duty_sh_d  = duty_sh_q;
      duty_act_d = duty_act_q;
      if (wrap_c) begin
         pwm_cnt_d  = '0;
         duty_act_d = duty_sh_q;
      end
      if (cfg_we && (cfg_addr == 2'd0)) begin
         duty_sh_d = cfg_data[PWM_BITS-1:0];
      end
   end

`ifdef LED_BLINK_EN
   logic [BLINK_W-1:0] blink_half_q, blink_half_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic [NLED-1:0]    blink_mask_q, blink_mask_d;
   logic               phase_q, phase_d;

   // Blink phase generator; a half-period write restarts on the on-phase
   always_comb begin
      blink_half_d = blink_half_q;
      blink_cnt_d  = blink_cnt_q + BLINK_W'(1);
      blink_mask_d = blink_mask_q;
      phase_d      = phase_q;
      if (cfg_we && (cfg_addr == 2'd1)) begin
         blink_half_d = cfg_data[BLINK_W-1:0];
         blink_cnt_d  = '0;
         phase_d      = 1'b1;
      end else if (blink_half_q == '0) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (blink_cnt_q == (blink_half_q - BLINK_W'(1))) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
      if (cfg_we && (cfg_addr == 2'd2)) begin
         blink_mask_d = cfg_data[NLED-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         blink_half_q <= '0;
         blink_cnt_q  <= '0;
         blink_mask_q <= '0;
         phase_q      <= 1'b1;
      end else begin
         blink_half_q <= blink_half_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_mask_q <= blink_mask_d;
         phase_q      <= phase_d;
      end
   end

   assign gate_c = ~blink_mask_q | {NLED{phase_q}};
`else
   logic [BLINK_W-1:0] unused_blink_half;

   assign unused_blink_half = cfg_data[BLINK_W-1:0];
   assign gate_c            = '1;
`endif

   always_comb begin
      pin_d = {i_ledg, i_ledr} & {NLED{on_c}} & gate_c;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pwm_cnt_q  <= '0;
         duty_sh_q  <= DMAX;
         duty_act_q <= DMAX;
         pin_q      <= '0;
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         duty_sh_q  <= duty_sh_d;
         duty_act_q <= duty_act_d;
         pin_q      <= pin_d;
      end
   end

   assign o_ledr_pin = pin_q[16:0];
   assign o_ledg_pin = pin_q[24:17];
   assign o_pwm_tick = wrap_c;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench for led_pwm_driver: per-cycle expected pins queued from a
// behavioural model, plus period-level on/off counts for the duty and blink cases.
module tb_led_pwm_driver;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [16:0] i_ledr;
   logic [7:0]  i_ledg;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic [16:0] o_ledr_pin;
   logic [7:0]  o_ledg_pin;
   logic        o_pwm_tick;

   always #5 clk_i = ~clk_i;

   led_pwm_driver dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_ledr     (i_ledr),
      .i_ledg     (i_ledg),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .o_ledr_pin (o_ledr_pin),
      .o_ledg_pin (o_ledg_pin),
      .o_pwm_tick (o_pwm_tick)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [24:0] exp_q[$];
   logic [24:0] last_pins;

   int          m_cnt, m_sh, m_act, m_half, m_bcnt;
   logic [24:0] m_mask;
   bit          m_phase;
   bit          m_valid = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [24:0] model_pins();
      logic [24:0] gate;
      bit          on;
      if (!rst_ni) return 25'h0;
      on = (m_act == 255) || (m_cnt < m_act);
`ifdef LED_BLINK_EN
      gate = ~m_mask | {25{m_phase}};
`else
      gate = '1;
`endif
      return on ? ({i_ledg, i_ledr} & gate) : 25'h0;
   endfunction

   task automatic model_update();
      if (!rst_ni) begin
         m_cnt = 0; m_sh = 255; m_act = 255;
         m_half = 0; m_bcnt = 0; m_phase = 1'b1; m_mask = '0;
         m_valid = 1'b1;
         return;
      end
      if (m_cnt == 254) begin
         m_act = m_sh;
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
`ifdef LED_BLINK_EN
      if (cfg_we && cfg_addr == 2'd1) begin
         m_half = int'(cfg_data[23:0]); m_bcnt = 0; m_phase = 1'b1;
      end else if (m_half == 0) begin
         m_bcnt = 0; m_phase = 1'b1;
      end else if (m_bcnt == m_half - 1) begin
         m_bcnt = 0; m_phase = !m_phase;
      end else begin
         m_bcnt++;
      end
      if (cfg_we && cfg_addr == 2'd2) m_mask = cfg_data[24:0];
`endif
      if (cfg_we && cfg_addr == 2'd0) m_sh = int'(cfg_data[7:0]);
   endtask

   // One clock: queue expectation, advance, compare registered pins
   task automatic cyc();
      logic [24:0] got;
      exp_q.push_back(model_pins());
      if (m_valid) check_eq("tick", 32'(o_pwm_tick), 32'(m_cnt == 254));
      @(posedge clk_i);
      model_update();
      #1;
      got = {o_ledg_pin, o_ledr_pin};
      check_eq("pins", 32'(got), 32'(exp_q.pop_front()));
      last_pins = got;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      cyc();
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 32'h0;
   endtask

   // Runs through the next tick cycle; afterwards pwm_cnt is 0
   task automatic wait_tick(output int n_off_g);
      int k = 0;
      n_off_g = 0;
      while (o_pwm_tick !== 1'b1 && k < 300) begin
         cyc();
         if (last_pins[24:17] == 8'h00) n_off_g++;
         k++;
      end
      check_eq("tick_seen", 32'(o_pwm_tick), 32'd1);
      cyc();
      if (last_pins[24:17] == 8'h00) n_off_g++;
   endtask

   task automatic measure(input int n, input logic [24:0] sel, output int n_on, output int n_off);
      n_on = 0; n_off = 0;
      for (int i = 0; i < n; i++) begin
         cyc();
         if ((last_pins & sel) == sel) n_on++;
         if ((last_pins & sel) == 25'h0) n_off++;
      end
   endtask

   localparam logic [24:0] SEL_R = 25'h001FFFF;
   localparam logic [24:0] SEL_G = 25'h1FE0000;

   initial begin
      int n_on, n_off, k;
      rst_ni = 1'b0; i_ledr = 17'h1FFFF; i_ledg = 8'h00;
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 32'h0;

      // Reset default: pins 0 in reset, then full brightness passthrough
      repeat (3) cyc();
      check_eq("rst_pins", 32'(last_pins), 32'h0);
      rst_ni = 1'b1;
      measure(300, SEL_R, n_on, n_off);
      check_eq("rst_full_on", n_on, 300);

      // Duty 64 written mid-period
      i_ledg = 8'hFF;
      repeat (40) cyc();
      cfg_write(2'd0, 32'hFFFF_FF40);
      wait_tick(n_off);
      check_eq("duty64_old_holds", n_off, 0);
      measure(255, SEL_G, n_on, n_off);
      check_eq("duty64_on", n_on, 64);
      check_eq("duty64_off", n_off, 191);

      // Duty 0: always off
      cfg_write(2'd0, 32'd0);
      wait_tick(n_off);
      measure(765, SEL_G, n_on, n_off);
      check_eq("duty0_on", n_on, 0);

      // Duty 255: no gap across wraps
      cfg_write(2'd0, 32'd255);
      wait_tick(n_off);
      measure(300, SEL_G, n_on, n_off);
      check_eq("duty255_off", n_off, 0);

      // Duty write on the tick cycle lands one period later
      k = 0;
      while (o_pwm_tick !== 1'b1 && k < 300) begin cyc(); k++; end
      check_eq("tick_found", 32'(o_pwm_tick), 32'd1);
      cfg_write(2'd0, 32'd64);
      measure(255, SEL_G, n_on, n_off);
      check_eq("tickwr_first_period", n_on, 255);
      measure(255, SEL_G, n_on, n_off);
      check_eq("tickwr_second_period", n_on, 64);

`ifdef LED_BLINK_EN
      // Blink on red bit 0 with half-period 5
      cfg_write(2'd0, 32'd255);
      wait_tick(n_off);
      i_ledr = 17'h3; i_ledg = 8'h00;
      cfg_write(2'd2, 32'h1);
      cfg_write(2'd1, 32'd5);
      for (int i = 0; i < 20; i++) begin
         cyc();
         check_eq("blink_bit0", 32'(last_pins[0]), 32'(((i / 5) % 2) == 0));
         check_eq("blink_bit1", 32'(last_pins[1]), 32'd1);
      end
      repeat (7) cyc();
      check_eq("blink_midoff", 32'(last_pins[0]), 32'd0);
      cfg_write(2'd1, 32'd5);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check_eq("blink_restart", 32'(last_pins[0]), 32'(i < 5));
      end
      cfg_write(2'd0, 32'd64);
      wait_tick(n_off);
`else
      // Blink writes ignored without the blink feature
      cfg_write(2'd2, 32'hFFFF_FFFF);
      cfg_write(2'd1, 32'd5);
      cfg_write(2'd0, 32'd128);
      wait_tick(n_off);
      measure(255, SEL_R | SEL_G, n_on, n_off);
      check_eq("noblink_on", n_on, 128);
      check_eq("noblink_off", n_off, 127);
      cfg_write(2'd0, 32'd64);
      wait_tick(n_off);
`endif

      // Reset mid-operation returns to full-on passthrough and pwm_cnt 0
      repeat (30) cyc();
      rst_ni = 1'b0;
      cyc();
      check_eq("midrst_pins", 32'(last_pins), 32'h0);
      rst_ni = 1'b1; i_ledr = 17'h1FFFF; i_ledg = 8'hFF;
      measure(254, SEL_R | SEL_G, n_on, n_off);
      check_eq("midrst_full_on", n_on, 254);
      check_eq("midrst_first_tick", 32'(o_pwm_tick), 32'd1);
      i_ledr = 17'h0A5A5; i_ledg = 8'h3C;
      cyc(); cyc();
      check_eq("midrst_track", 32'(last_pins), 32'({8'h3C, 17'h0A5A5}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
